// File: rtl/pulse_req_ack_arb.sv
// Event pulses are counted per channel in saturating counters. A round-robin
// arbiter serves one pending event at a time over a four-phase req/ack link.
module pulse_req_ack_arb #(
    parameter int CH_NUM    = 4,
    parameter int CNT_W     = 3,
    parameter int SYNC_STEP = 2,
    localparam int ID_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH_NUM-1:0]       pulse_in,
    input  logic [CH_NUM-1:0]       ch_en,
    input  logic [CH_NUM-1:0]       ovf_clr,
    output logic                    req_out,
    output logic [ID_W-1:0]         req_id,
    input  logic                    ack_in,
    output logic [CH_NUM*CNT_W-1:0] pend_cnt,
    output logic [CH_NUM-1:0]       overflow,
    output logic [CH_NUM-1:0]       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_REL  = 2'd2
    } state_t;

    localparam logic [ID_W:0]    CH_NUM_W = (ID_W + 1)'(CH_NUM);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    function automatic logic [ID_W-1:0] id_wrap_add(input logic [ID_W-1:0] base,
                                                    input logic [ID_W-1:0] off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= CH_NUM_W) begin
            sum = sum - CH_NUM_W;
        end else begin
            sum = sum;
        end
        return sum[ID_W-1:0];
    endfunction

    state_t                        state_q, state_d;
    logic [SYNC_STEP-1:0]          ack_sync_q, ack_sync_d;
    logic [SYNC_STEP-1:0]          sync_vld_q, sync_vld_d;
    logic                          req_out_q, req_out_d;
    logic [ID_W-1:0]               req_id_q, req_id_d;
    logic [ID_W-1:0]               rr_ptr_q, rr_ptr_d;
    logic [CH_NUM-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [CH_NUM-1:0]             overflow_q, overflow_d;
    logic [CH_NUM-1:0]             busy_q, busy_d;

    logic                          ack_s;
    logic                          sync_ok_s;
    logic [CH_NUM-1:0]             cnt_nz_s;
    logic [CH_NUM-1:0]             cand_s;
    logic [CH_NUM-1:0]             rot_s;
    logic [ID_W-1:0]               off_s;
    logic [ID_W-1:0]               grant_id_s;
    logic                          cand_any_s;
    logic                          dec_s;

    // ack_in synchroniser; sync_vld marks when the pipeline holds real samples,
    // so a reset mid-handshake cannot mistake the cleared flops for ack low.
    always_comb begin
        ack_sync_d = {ack_sync_q[SYNC_STEP-2:0], ack_in};
        sync_vld_d = {sync_vld_q[SYNC_STEP-2:0], 1'b1};
        ack_s      = ack_sync_q[SYNC_STEP-1];
        sync_ok_s  = sync_vld_q[SYNC_STEP-1];
    end

    // Round-robin pick: rotate candidates so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        cnt_nz_s = {CH_NUM{1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            cnt_nz_s[i] = (cnt_q[i] != {CNT_W{1'b0}});
        end
        cand_s     = ch_en & cnt_nz_s;
        rot_s      = CH_NUM'({cand_s, cand_s} >> rr_ptr_q);
        off_s      = {ID_W{1'b0}};
        cand_any_s = 1'b0;
        for (int k = CH_NUM - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                cand_any_s = 1'b1;
                off_s      = ID_W'(k);
            end else begin
                cand_any_s = cand_any_s;
            end
        end
        grant_id_s = id_wrap_add(rr_ptr_q, off_s);
    end

    // Handshake FSM: next state, request outputs and the decrement strobe.
    always_comb begin
        state_d   = state_q;
        req_out_d = req_out_q;
        req_id_d  = req_id_q;
        rr_ptr_d  = rr_ptr_q;
        dec_s     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sync_ok_s && !ack_s && cand_any_s) begin
                    req_id_d  = grant_id_s;
                    req_out_d = 1'b1;
                    state_d   = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (ack_s) begin
                    req_out_d = 1'b0;
                    dec_s     = 1'b1;
                    state_d   = S_REL;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REL: begin
                if (!ack_s) begin
                    rr_ptr_d = id_wrap_add(req_id_q, ID_W'(1'b1));
                    state_d  = S_IDLE;
                end else begin
                    state_d = S_REL;
                end
            end
            default: begin
                req_out_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
    end

    // Pending counters: a pulse and a decrement in the same cycle cancel out.
    always_comb begin
        cnt_d      = cnt_q;
        overflow_d = overflow_q & ~ovf_clr;
        for (int i = 0; i < CH_NUM; i++) begin
            case ({pulse_in[i], dec_s && (req_id_q == ID_W'(i))})
                2'b10: begin
                    if (cnt_q[i] == CNT_MAX) begin
                        overflow_d[i] = 1'b1;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1'b1);
                    end
                end
                2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1'b1);
                default: cnt_d[i] = cnt_q[i];
            endcase
        end
    end

    // busy is computed from next-state values so the flop matches count/FSM state.
    always_comb begin
        busy_d = {CH_NUM{1'b0}};
        for (int i = 0; i < CH_NUM; i++) begin
            busy_d[i] = (cnt_d[i] != {CNT_W{1'b0}}) ||
                        ((state_d != S_IDLE) && (req_id_d == ID_W'(i)));
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ack_sync_q <= {SYNC_STEP{1'b0}};
            sync_vld_q <= {SYNC_STEP{1'b0}};
            req_out_q  <= 1'b0;
            req_id_q   <= {ID_W{1'b0}};
            rr_ptr_q   <= {ID_W{1'b0}};
            cnt_q      <= {(CH_NUM * CNT_W){1'b0}};
            overflow_q <= {CH_NUM{1'b0}};
            busy_q     <= {CH_NUM{1'b0}};
        end else begin
            state_q    <= state_d;
            ack_sync_q <= ack_sync_d;
            sync_vld_q <= sync_vld_d;
            req_out_q  <= req_out_d;
            req_id_q   <= req_id_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
        end
    end

    assign req_out  = req_out_q;
    assign req_id   = req_id_q;
    assign pend_cnt = cnt_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_pulse_req_ack_arb.sv
// Self-checking bench for pulse_req_ack_arb: grant-order scoreboard, a
// saturation vector table and hand-written handshake corner sequences.
module tb_pulse_req_ack_arb;

    localparam int CH = 4;
    localparam int CW = 3;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] pulse_in = '0;
    logic [CH-1:0] ch_en = 4'b1111;
    logic [CH-1:0] ovf_clr = '0;
    logic          ack_in = 1'b0;
    logic          req_out;
    logic [IW-1:0] req_id;
    logic [CH*CW-1:0] pend_cnt;
    logic [CH-1:0] overflow;
    logic [CH-1:0] busy;

    int   checks = 0;
    int   errors = 0;
    int   exp_q[$];
    logic prev_req = 1'b0;
    logic ack_auto = 1'b0;
    logic [2:0] ack_dly = 3'b000;

    typedef struct {
        logic          pulse;
        logic          clr;
        logic [CW-1:0] cnt;
        logic          ovf;
    } vec_t;
    vec_t vecs[13];

    pulse_req_ack_arb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .ch_en    (ch_en),
        .ovf_clr  (ovf_clr),
        .req_out  (req_out),
        .req_id   (req_id),
        .ack_in   (ack_in),
        .pend_cnt (pend_cnt),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [CW-1:0] cnt_of(input int ch);
        return pend_cnt[ch*CW +: CW];
    endfunction

    // One clock: settle after the edge, model the delayed ack, score new grants.
    task automatic step();
        int e;
        @(posedge clk);
        #1;
        if (ack_auto) begin
            ack_dly = {ack_dly[1:0], req_out};
            ack_in  = ack_dly[2];
        end
        if (req_out && !prev_req) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_grant actual=%0d required=none", req_id);
            end else begin
                e = exp_q.pop_front();
                chk("grant_id", 32'(req_id), 32'(e));
            end
        end
        prev_req = req_out;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        pulse_in = '0;
        ovf_clr  = '0;
        ch_en    = 4'b1111;
        ack_in   = 1'b0;
        ack_auto = 1'b0;
        ack_dly  = 3'b000;
        exp_q.delete();
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || req_out || busy != '0) && n < 300) begin
            step();
            n++;
        end
        chk({name, "_drained"}, 32'(n < 300), 32'd1);
        chk({name, "_cnt_zero"}, 32'(pend_cnt), 32'd0);
    endtask

    initial begin
        int   n;
        int   sent;
        logic [CW-1:0] prevc;

        for (int i = 0; i < 9; i++) begin
            vecs[i] = '{1'b1, 1'b0, CW'((i < 7) ? i + 1 : 7), (i >= 7)};
        end
        vecs[9]  = '{1'b0, 1'b1, 3'd7, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 3'd7, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 3'd7, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 3'd7, 1'b0};

        // Reset state
        step();
        step();
        chk("rst_req_out", 32'(req_out), 32'd0);
        chk("rst_req_id", 32'(req_id), 32'd0);
        chk("rst_pend", 32'(pend_cnt), 32'd0);
        chk("rst_ovf_busy", 32'({overflow, busy}), 32'd0);
        do_reset();

        // Single pulse on channel 2, ack follows req with a delay
        ack_auto = 1'b1;
        pulse_in = 4'b0100;
        exp_q.push_back(2);
        step();
        pulse_in = '0;
        chk("t1_cnt_after_pulse", 32'(cnt_of(2)), 32'd1);
        chk("t1_req_early", 32'(req_out), 32'd0);
        step();
        chk("t1_req_high", 32'(req_out), 32'd1);
        chk("t1_busy2", 32'(busy[2]), 32'd1);
        prevc = cnt_of(2);
        n = 0;
        while (req_out && n < 30) begin
            prevc = cnt_of(2);
            step();
            n++;
        end
        chk("t1_fall_seen", 32'(n < 30), 32'd1);
        chk("t1_cnt_before_fall", 32'(prevc), 32'd1);
        chk("t1_cnt_after_fall", 32'(cnt_of(2)), 32'd0);
        drain("t1");

        // Simultaneous pulses on 0,1,3; re-pulse 0 while 3 is in service
        do_reset();
        ack_auto = 1'b1;
        pulse_in = 4'b1011;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        step();
        pulse_in = '0;
        sent = 0;
        n = 0;
        while (sent == 0 && n < 200) begin
            step();
            n++;
            if (req_out && req_id == 2'd3) begin
                pulse_in = 4'b0001;
                exp_q.push_back(0);
                step();
                pulse_in = '0;
                sent = 1;
            end
        end
        chk("t2_repulse_sent", 32'(sent), 32'd1);
        drain("t2");

        // Saturation and sticky overflow on channel 1, ack held low
        do_reset();
        exp_q.push_back(1);
        for (int i = 0; i < 13; i++) begin
            pulse_in = {2'b00, vecs[i].pulse, 1'b0};
            ovf_clr  = {2'b00, vecs[i].clr, 1'b0};
            step();
            chk($sformatf("t3_cnt_row%0d", i), 32'(cnt_of(1)), 32'(vecs[i].cnt));
            chk($sformatf("t3_ovf_row%0d", i), 32'(overflow[1]), 32'(vecs[i].ovf));
        end
        pulse_in = '0;
        ovf_clr  = '0;
        chk("t3_req_held", 32'(req_out), 32'd1);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // Pulse on channel 0 in the cycle ack_s rises
        do_reset();
        pulse_in = 4'b0001;
        exp_q.push_back(0);
        step();
        pulse_in = '0;
        step();
        chk("t4_req_high", 32'(req_out), 32'd1);
        ack_in = 1'b1;
        step();
        step();
        chk("t4_req_still_high", 32'(req_out), 32'd1);
        pulse_in = 4'b0001;
        step();
        pulse_in = '0;
        chk("t4_req_fell", 32'(req_out), 32'd0);
        chk("t4_cnt_unchanged", 32'(cnt_of(0)), 32'd1);
        ack_dly  = 3'b000;
        ack_auto = 1'b1;
        exp_q.push_back(0);
        drain("t4");

        // Reset mid-handshake with ack_in still high
        do_reset();
        pulse_in = 4'b0010;
        exp_q.push_back(1);
        step();
        pulse_in = '0;
        step();
        ack_in = 1'b1;
        step();
        chk("t5_req_before_rst", 32'(req_out), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_req", 32'(req_out), 32'd0);
        chk("t5_rst_id", 32'(req_id), 32'd0);
        chk("t5_rst_pend", 32'(pend_cnt), 32'd0);
        chk("t5_rst_ovf_busy", 32'({overflow, busy}), 32'd0);
        step();
        step();
        rst_n    = 1'b1;
        pulse_in = 4'b0100;
        exp_q.push_back(2);
        step();
        pulse_in = '0;
        sent = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (req_out) sent++;
        end
        chk("t5_no_req_ack_high", 32'(sent), 32'd0);
        ack_in = 1'b0;
        step();
        chk("t5_no_req_sync1", 32'(req_out), 32'd0);
        step();
        chk("t5_no_req_sync2", 32'(req_out), 32'd0);
        ack_dly  = 3'b000;
        ack_auto = 1'b1;
        drain("t5");

        // ch_en masks channel 2 until re-enabled
        do_reset();
        ch_en    = 4'b1011;
        ack_auto = 1'b1;
        pulse_in = 4'b1100;
        exp_q.push_back(3);
        step();
        pulse_in = '0;
        n = 0;
        while ((exp_q.size() != 0 || busy[3]) && n < 100) begin
            step();
            n++;
        end
        chk("t6_ch3_done", 32'(n < 100), 32'd1);
        repeat (10) step();
        chk("t6_cnt2", 32'(cnt_of(2)), 32'd1);
        chk("t6_busy2", 32'(busy[2]), 32'd1);
        chk("t6_cnt3", 32'(cnt_of(3)), 32'd0);
        exp_q.push_back(2);
        ch_en = 4'b1111;
        drain("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
